// File: rtl/ssd_reader.sv
// Reads an asynchronous active-low 7-segment pattern, debounces it, and hands
// decoded BCD digits to a consumer through a one-deep valid/ready holding stage.
module ssd_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    input  logic       ovr_clr,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_err,
    output logic       overrun
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DIG_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [SEG_W-1:0] SEG_IDLE = '1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state, state_nxt;
    logic [SEG_W-1:0] s1, s2, sq, last_pat;
    logic [CNT_W-1:0] cnt;
    logic             first_flag;
    logic             capture_c;
    logic             load_c;
    logic             ovr_set_c;
    logic [DIG_W-1:0] dec_digit_c;
    logic             dec_err_c;

    // Two-flop synchroniser plus one delayed copy for stability comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= SEG_IDLE;
            s2 <= SEG_IDLE;
            sq <= SEG_IDLE;
        end else begin
            s1 <= seg_in;
            s2 <= s1;
            sq <= s2;
        end
    end

    // Stability counter saturates so a held pattern never re-triggers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (s2 != sq) begin
            cnt <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign capture_c = (s2 == sq) && (cnt == CNT_LAST) && (first_flag || (s2 != last_pat));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pat   <= SEG_IDLE;
            first_flag <= 1'b1;
        end else if (capture_c) begin
            last_pat   <= s2;
            first_flag <= 1'b0;
        end
    end

    always_comb begin
        dec_digit_c = 4'hF;
        dec_err_c   = 1'b0;
        case (s2)
            7'b0000010: dec_digit_c = 4'd0;
            7'b1000000: dec_digit_c = 4'd1;
            7'b1111111: dec_digit_c = 4'd2;
            7'b0000000: dec_digit_c = 4'd3;
            7'b0000110: dec_digit_c = 4'd4;
            7'b1111001: dec_digit_c = 4'd5;
            7'b0001000: dec_digit_c = 4'd6;
            7'b1000001: dec_digit_c = 4'd7;
            7'b0001111: dec_digit_c = 4'd8;
            7'b1010101: dec_digit_c = 4'd9;
            default:    dec_err_c   = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A capture while full is only taken if the old result leaves this cycle
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        ovr_set_c = 1'b0;
        case (state)
            EMPTY: begin
                if (capture_c) begin
                    state_nxt = FULL;
                    load_c    = 1'b1;
                end
            end
            FULL: begin
                if (capture_c && out_ready) begin
                    load_c = 1'b1;
                end else if (capture_c) begin
                    ovr_set_c = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_digit <= '0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load_c) begin
                out_digit <= dec_digit_c;
                out_err   <= dec_err_c;
            end
            if (ovr_set_c) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_ssd_reader.sv
// Bench for ssd_reader: two instances (STABLE_CYCLES 4 and 1) driven by the same
// stimulus and compared every cycle against a run-length based reference model.
module tb_ssd_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg_in = 7'b1000000;
    logic       out_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       valid0, err0, ovr0, valid1, err1, ovr1;
    logic [3:0] digit0, digit1;

    int checks = 0;
    int errors = 0;
    logic [7:0] acc[$];

    logic [6:0] pat_tab [10] = '{7'b0000010, 7'b1000000, 7'b1111111, 7'b0000000, 7'b0000110,
                                 7'b1111001, 7'b0001000, 7'b1000001, 7'b0001111, 7'b1010101};

    // Model state per instance: sample history (newest first) and output view
    logic [7:0] hist [2][16];
    bit         mfirst [2];
    logic [6:0] mlast [2];
    logic       mvalid [2];
    logic [3:0] mdigit [2];
    logic       merr [2];
    logic       movr [2];

    ssd_reader #(.STABLE_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .out_ready(out_ready), .ovr_clr(ovr_clr),
        .out_valid(valid0), .out_digit(digit0), .out_err(err0), .overrun(ovr0));

    ssd_reader #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .seg_in(seg_in), .out_ready(out_ready), .ovr_clr(ovr_clr),
        .out_valid(valid1), .out_digit(digit1), .out_err(err1), .overrun(ovr1));

    always #5 clk = ~clk;

    function automatic logic [4:0] mdec(input logic [6:0] p);
        logic [4:0] res;
        res = 5'h1F;
        for (int i = 0; i < 10; i++) begin
            if (pat_tab[i] == p) res = {1'b0, 4'(i)};
        end
        return res;
    endfunction

    task automatic mreset(input int k);
        for (int j = 0; j < 16; j++) hist[k][j] = (j < 3) ? 8'h7F : 8'h80;
        mfirst[k] = 1'b1;
        mlast[k]  = 7'h7F;
        mvalid[k] = 1'b0;
        mdigit[k] = 4'h0;
        merr[k]   = 1'b0;
        movr[k]   = 1'b0;
    endtask

    // A pattern is reported when its run at the synchroniser output reaches s+1 samples
    task automatic mstep(input int k, input int s);
        int r;
        bit ev, set;
        logic [6:0] v;
        logic [4:0] d;
        r = 1;
        while (r < 15 && hist[k][r+1] == hist[k][1]) r++;
        v  = hist[k][1][6:0];
        ev = (r == s + 1) && (mfirst[k] || v != mlast[k]);
        for (int j = 15; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = {1'b0, seg_in};
        set = 1'b0;
        if (ev) begin
            mfirst[k] = 1'b0;
            mlast[k]  = v;
            d = mdec(v);
            if (!mvalid[k] || out_ready) begin
                mvalid[k] = 1'b1;
                mdigit[k] = d[3:0];
                merr[k]   = d[4];
            end else begin
                set = 1'b1;
            end
        end else if (mvalid[k] && out_ready) begin
            mvalid[k] = 1'b0;
        end
        if (set) movr[k] = 1'b1;
        else if (ovr_clr) movr[k] = 1'b0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mreset(0);
            mreset(1);
        end else begin
            mstep(0, 4);
            mstep(1, 1);
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        if (valid0 && out_ready) acc.push_back({3'b0, err0, digit0});
        @(posedge clk);
        @(negedge clk);
        chk("model_valid0", 8'(valid0), 8'(mvalid[0]));
        chk("model_digit0", 8'(digit0), 8'(mdigit[0]));
        chk("model_err0",   8'(err0),   8'(merr[0]));
        chk("model_ovr0",   8'(ovr0),   8'(movr[0]));
        chk("model_valid1", 8'(valid1), 8'(mvalid[1]));
        chk("model_digit1", 8'(digit1), 8'(mdigit[1]));
        chk("model_err1",   8'(err1),   8'(merr[1]));
        chk("model_ovr1",   8'(ovr1),   8'(movr[1]));
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg_in = p;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int len;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid0", 8'(valid0), 8'h0);
        chk("rst_digit0", 8'(digit0), 8'h0);
        chk("rst_err0",   8'(err0),   8'h0);
        chk("rst_ovr0",   8'(ovr0),   8'h0);
        chk("rst_valid1", 8'(valid1), 8'h0);
        cyc();
        cyc();
        rst = 1'b0;

        // Latency: valid rises after edge 6
        for (int i = 0; i < 6; i++) cyc();
        chk("lat_valid_e5", 8'(valid0), 8'h0);
        cyc();
        chk("lat_valid_e6", 8'(valid0), 8'h1);
        chk("lat_digit",    8'(digit0), 8'h1);
        chk("lat_err",      8'(err0),   8'h0);

        // Valid then invalid pattern with consumer ready
        out_ready = 1'b1;
        cyc();
        acc.delete();
        hold(7'b1010101, 10);
        hold(7'b0110110, 10);
        chk("two_count", 8'(acc.size()), 8'h2);
        chk("two_first", (acc.size() > 0) ? acc[0] : 8'hEE, 8'h09);
        chk("two_second", (acc.size() > 1) ? acc[1] : 8'hEE, 8'h1F);

        // Short glitch and return to the same pattern give no new result
        acc.delete();
        hold(7'b0000000, 10);
        hold(7'b0001111, 3);
        hold(7'b0000000, 10);
        chk("glitch_count", 8'(acc.size()), 8'h1);
        chk("glitch_digit", (acc.size() > 0) ? acc[0] : 8'hEE, 8'h03);
        chk("glitch_valid", 8'(valid0), 8'h0);

        // Overrun while consumer stalls, then clear
        out_ready = 1'b0;
        hold(7'b1111001, 10);
        hold(7'b1000001, 10);
        chk("ovr_valid", 8'(valid0), 8'h1);
        chk("ovr_digit", 8'(digit0), 8'h5);
        chk("ovr_flag",  8'(ovr0),   8'h1);
        ovr_clr = 1'b1;
        cyc();
        ovr_clr = 1'b0;
        chk("ovr_cleared", 8'(ovr0), 8'h0);
        chk("ovr_held",    8'(digit0), 8'h5);

        // New capture coincides with acceptance of the held result
        hold(7'b0001000, 6);
        chk("same_pre_digit", 8'(digit0), 8'h5);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("same_valid", 8'(valid0), 8'h1);
        chk("same_digit", 8'(digit0), 8'h6);
        chk("same_ovr",   8'(ovr0),   8'h0);
        hold(7'b0001000, 3);
        chk("same_stable", 8'(digit0), 8'h6);

        // Reset mid-count; all-dark pattern reported first after release
        hold(7'b1000000, 2);
        rst = 1'b1;
        #1;
        chk("midrst_valid0", 8'(valid0), 8'h0);
        chk("midrst_valid1", 8'(valid1), 8'h0);
        seg_in = 7'h7F;
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        chk("s1_valid", 8'(valid1), 8'h1);
        chk("s1_digit", 8'(digit1), 8'h2);
        chk("s1_err",   8'(err1),   8'h0);
        chk("s4_digit", 8'(digit0), 8'h2);

        // Random patterns, hold times and handshakes against the model
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(4) == 0) seg_in = 7'($urandom);
            else seg_in = pat_tab[$urandom_range(9)];
            len = int'($urandom_range(8, 1));
            for (int i = 0; i < len; i++) begin
                out_ready = 1'($urandom_range(1));
                ovr_clr   = ($urandom_range(7) == 0);
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
